// File: rtl/rangefinder_capture_pkg.sv
// Shared constants for the rangefinder sample capture controller:
// CSR word addresses, CTRL/STATUS bit positions and the capture FSM states.
package rangefinder_capture_pkg;

   // CSR word addresses
   localparam logic [1:0] CSR_CTRL   = 2'd0;
   localparam logic [1:0] CSR_STATUS = 2'd1;
   localparam logic [1:0] CSR_COUNT  = 2'd2;
   localparam logic [1:0] CSR_WPTR   = 2'd3;

   // CTRL bits (ARM/ABORT/SW_TRIG are write-1 pulses, IRQ_EN is sticky)
   localparam int CTRL_ARM     = 0;
   localparam int CTRL_ABORT   = 1;
   localparam int CTRL_SW_TRIG = 2;
   localparam int CTRL_IRQ_EN  = 3;

   // STATUS bits
   localparam int STAT_BUSY      = 0;
   localparam int STAT_DONE      = 1;
   localparam int STAT_TRIG_LOST = 2;
   localparam int STAT_ARMED     = 3;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARMED   = 2'd1,
      S_CAPTURE = 2'd2
   } cap_state_e;

endpackage

// File: rtl/rangefinder_trig_edge.sv
// Rising-edge detector for the hardware trigger. The previous-level register
// is forced high during reset so a trigger that is already high when reset
// releases is not seen as an edge; only a low-to-high transition counts.
module rangefinder_trig_edge (
   input  logic clk,
   input  logic reset,
   input  logic trig_i,
   output logic edge_o
);

   logic prev_q;

   // Remember last cycle's trigger level (masked high through reset)
   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q <= 1'b1;
      end else begin
         prev_q <= trig_i;
      end
   end

   assign edge_o = trig_i & ~prev_q;

endmodule

// File: rtl/rangefinder_sample_capture_ctrl.sv
// Rangefinder sample capture controller.
// A CSR slave arms a capture; a trigger (hardware edge or SW_TRIG) starts it,
// and COUNT consecutive valid ADC samples are written to the sample RAM's
// second port from address 0 with one cycle of latency. Completion sets DONE
// and raises irq when IRQ_EN is set.
// Optional build macro RANGEFINDER_CAPTURE_DECIM_EN: makes CSR 3 writable with
// a DECIM field in bits 31:24 and keeps one of every DECIM+1 valid samples.
module rangefinder_sample_capture_ctrl
   import rangefinder_capture_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        avs_address,
   input  logic              avs_chipselect,
   input  logic              avs_write,
   input  logic              avs_read,
   input  logic [31:0]       avs_writedata,
   output logic [31:0]       avs_readdata,
   input  logic              smp_valid,
   input  logic [DATA_W-1:0] smp_data,
   input  logic              trig_in,
   output logic [ADDR_W-1:0] ram_address,
   output logic              ram_chipselect,
   output logic              ram_write,
   output logic [DATA_W-1:0] ram_writedata,
   output logic              irq
);

   localparam int            CW         = ADDR_W + 1;
   localparam logic [CW-1:0] FULL_CNT   = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [31:0]   FULL_CNT32 = 32'(FULL_CNT);

   cap_state_e          state_q, state_d;
   logic [CW-1:0]       wptr_q;
   logic [CW-1:0]       count_q;
   logic [CW-1:0]       count_act_q;
   logic [CW-1:0]       count_wr_val;
   logic                done_q;
   logic                trig_lost_q;
   logic                irq_en_q;
   logic                last_wr_q;
   logic                ram_write_q;
   logic [ADDR_W-1:0]   ram_address_q;
   logic [DATA_W-1:0]   ram_writedata_q;
   logic [31:0]         readdata_q;
   logic [31:0]         rd_mux;

   logic csr_wr, ctrl_wr, status_wr, count_wr;
   logic arm_req, abort_req, swtrig_req;
   logic trig_edge, keep;
   logic accept, last, start_cap, arm_go, lost_set;

   // ---------------- CSR write decode ----------------
   assign csr_wr     = avs_chipselect & avs_write;
   assign ctrl_wr    = csr_wr && (avs_address == CSR_CTRL);
   assign status_wr  = csr_wr && (avs_address == CSR_STATUS);
   assign count_wr   = csr_wr && (avs_address == CSR_COUNT);
   assign arm_req    = ctrl_wr & avs_writedata[CTRL_ARM];
   assign abort_req  = ctrl_wr & avs_writedata[CTRL_ABORT];
   assign swtrig_req = ctrl_wr & avs_writedata[CTRL_SW_TRIG];

   // Clamp COUNT writes: zero or anything beyond the RAM depth means full depth
   always_comb begin
      count_wr_val = FULL_CNT;
      if (avs_writedata != '0 && avs_writedata <= FULL_CNT32) begin
         count_wr_val = avs_writedata[CW-1:0];
      end
   end

   rangefinder_trig_edge u_trig_edge (
      .clk    (clk),
      .reset  (reset),
      .trig_i (trig_in),
      .edge_o (trig_edge)
   );

`ifdef RANGEFINDER_CAPTURE_DECIM_EN
   logic [7:0] decim_q;
   logic [7:0] dcnt_q;
   logic       wptr_wr;

   assign wptr_wr = csr_wr && (avs_address == CSR_WPTR);
   assign keep    = (dcnt_q == 8'd0);

   // Decimation: counter restarts on entry to CAPTURE so the first sample is kept
   always_ff @(posedge clk) begin
      if (reset) begin
         decim_q <= '0;
         dcnt_q  <= '0;
      end else begin
         if (wptr_wr) begin
            decim_q <= avs_writedata[31:24];
         end
         if (start_cap) begin
            dcnt_q <= '0;
         end else if (state_q == S_CAPTURE && smp_valid) begin
            dcnt_q <= (dcnt_q >= decim_q) ? 8'd0 : dcnt_q + 8'd1;
         end
      end
   end
`else
   assign keep = 1'b1;
`endif

   // Capture FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state plus the per-cycle capture strobes; ABORT outranks everything
   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      last      = 1'b0;
      start_cap = 1'b0;
      arm_go    = 1'b0;
      lost_set  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (arm_req && !abort_req) begin
               state_d = S_ARMED;
               arm_go  = 1'b1;
            end
         end
         S_ARMED: begin
            if (abort_req) begin
               state_d = S_IDLE;
            end else if (trig_edge || swtrig_req) begin
               state_d   = S_CAPTURE;
               start_cap = 1'b1;
            end
         end
         S_CAPTURE: begin
            lost_set = trig_edge;
            if (abort_req) begin
               state_d = S_IDLE;
            end else if (smp_valid && keep) begin
               accept = 1'b1;
               if ((wptr_q + CW'(1)) == count_act_q) begin
                  last    = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Write pointer, RAM port driver and status flags
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q          <= '0;
         count_q         <= FULL_CNT;
         count_act_q     <= FULL_CNT;
         done_q          <= 1'b0;
         trig_lost_q     <= 1'b0;
         irq_en_q        <= 1'b0;
         last_wr_q       <= 1'b0;
         ram_write_q     <= 1'b0;
         ram_address_q   <= '0;
         ram_writedata_q <= '0;
      end else begin
         ram_write_q <= accept;
         last_wr_q   <= last;
         if (accept) begin
            ram_address_q   <= wptr_q[ADDR_W-1:0];
            ram_writedata_q <= smp_data;
            wptr_q          <= wptr_q + CW'(1);
         end

         if (ctrl_wr) begin
            irq_en_q <= avs_writedata[CTRL_IRQ_EN];
         end
         if (count_wr) begin
            count_q <= count_wr_val;
         end

         // DONE: clear-on-write, then set by the final RAM write, then cleared by ARM
         if (status_wr && avs_writedata[STAT_DONE]) begin
            done_q <= 1'b0;
         end
         if (last_wr_q) begin
            done_q <= 1'b1;
         end
         if (arm_go) begin
            done_q      <= 1'b0;
            wptr_q      <= '0;
            count_act_q <= count_q;
         end

         if (status_wr && avs_writedata[STAT_TRIG_LOST]) begin
            trig_lost_q <= 1'b0;
         end
         if (lost_set) begin
            trig_lost_q <= 1'b1;
         end
      end
   end

   // CSR read mux
   always_comb begin
      rd_mux = '0;
      case (avs_address)
         CSR_CTRL: begin
            rd_mux[CTRL_IRQ_EN] = irq_en_q;
         end
         CSR_STATUS: begin
            rd_mux[STAT_BUSY]      = (state_q != S_IDLE);
            rd_mux[STAT_DONE]      = done_q;
            rd_mux[STAT_TRIG_LOST] = trig_lost_q;
            rd_mux[STAT_ARMED]     = (state_q == S_ARMED);
         end
         CSR_COUNT: begin
            rd_mux[CW-1:0] = count_q;
         end
         default: begin
            rd_mux[CW-1:0] = wptr_q;
`ifdef RANGEFINDER_CAPTURE_DECIM_EN
            rd_mux[31:24]  = decim_q;
`endif
         end
      endcase
   end

   // Registered read data, held between reads
   always_ff @(posedge clk) begin
      if (reset) begin
         readdata_q <= '0;
      end else if (avs_chipselect && avs_read) begin
         readdata_q <= rd_mux;
      end
   end

   assign avs_readdata   = readdata_q;
   assign ram_address    = ram_address_q;
   assign ram_chipselect = ram_write_q;
   assign ram_write      = ram_write_q;
   assign ram_writedata  = ram_writedata_q;
   assign irq            = done_q & irq_en_q;

endmodule

// File: tb/tb_rangefinder_sample_capture_ctrl.sv
// Self-checking bench for rangefinder_sample_capture_ctrl.
// Expected RAM contents come from the list of offered samples filtered by the
// capture rules (skip the trigger cycle, keep first COUNT, optional decimation).
// Covers RANGEFINDER_CAPTURE_DECIM_EN when that macro is defined.
module tb_rangefinder_sample_capture_ctrl;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic [1:0]        avs_address;
   logic              avs_chipselect;
   logic              avs_write;
   logic              avs_read;
   logic [31:0]       avs_writedata;
   logic [31:0]       avs_readdata;
   logic              smp_valid;
   logic [DATA_W-1:0] smp_data;
   logic              trig_in;
   logic [ADDR_W-1:0] ram_address;
   logic              ram_chipselect;
   logic              ram_write;
   logic [DATA_W-1:0] ram_writedata;
   logic              irq;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      int c;
      int a;
      int d;
   } wr_t;

   wr_t  wq[$];
   int   irq_rise = -1;
   logic irq_prev = 1'b0;

   rangefinder_sample_capture_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk            (clk),
      .reset          (reset),
      .avs_address    (avs_address),
      .avs_chipselect (avs_chipselect),
      .avs_write      (avs_write),
      .avs_read       (avs_read),
      .avs_writedata  (avs_writedata),
      .avs_readdata   (avs_readdata),
      .smp_valid      (smp_valid),
      .smp_data       (smp_data),
      .trig_in        (trig_in),
      .ram_address    (ram_address),
      .ram_chipselect (ram_chipselect),
      .ram_write      (ram_write),
      .ram_writedata  (ram_writedata),
      .irq            (irq)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every RAM write and the cycle irq first rises
   always @(negedge clk) begin
      wr_t w;
      if (ram_write) begin
         w.c = cyc;
         w.a = int'(ram_address);
         w.d = int'(ram_writedata);
         wq.push_back(w);
      end
      if (irq && !irq_prev) irq_rise = cyc;
      irq_prev = irq;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
      avs_chipselect = 1'b1;
      avs_write      = 1'b1;
      avs_address    = a;
      avs_writedata  = d;
      step();
      avs_chipselect = 1'b0;
      avs_write      = 1'b0;
   endtask

   task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
      avs_chipselect = 1'b1;
      avs_read       = 1'b1;
      avs_address    = a;
      step();
      avs_chipselect = 1'b0;
      avs_read       = 1'b0;
      d = avs_readdata;
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      reset   = 1'b1;
      trig_in = 1'b1;   // held high across reset release: must not count as an edge
      repeat (3) step();
      total++;
      if ({avs_readdata, ram_address, ram_writedata, ram_write, ram_chipselect, irq} !== '0) begin
         bad++;
         $display("FAIL reset_outputs rd=%h addr=%h data=%h wr=%b cs=%b irq=%b exp all 0",
                  avs_readdata, ram_address, ram_writedata, ram_write, ram_chipselect, irq);
      end
      reset = 1'b0;
      step();
      csr_rd(2'd1, rd);
      total++;
      if (rd !== 32'h0) begin bad++; $display("FAIL reset_status got=%h exp=%h", rd, 32'h0); end
      csr_rd(2'd2, rd);
      total++;
      if (rd !== 32'd256) begin bad++; $display("FAIL reset_count got=%0d exp=256", rd); end
      csr_rd(2'd0, rd);
      total++;
      if (rd !== 32'h0) begin bad++; $display("FAIL reset_ctrl got=%h exp=0", rd); end
      csr_rd(2'd3, rd);
      total++;
      if (rd !== 32'h0) begin bad++; $display("FAIL reset_wptr got=%h exp=0", rd); end
   endtask

   task automatic test_level_trigger();
      logic [31:0] rd;
      csr_wr(2'd2, 32'd4);
      csr_wr(2'd0, 32'h1);
      wq.delete();
      for (int i = 0; i < 20; i++) begin
         smp_valid = 1'($urandom_range(0, 1));
         smp_data  = 8'($urandom);
         step();
      end
      smp_valid = 1'b0;
      repeat (2) step();
      total++;
      if (wq.size() != 0) begin bad++; $display("FAIL level_no_write got=%0d writes exp=0", wq.size()); end
      csr_rd(2'd1, rd);
      total++;
      if (rd !== 32'h9) begin bad++; $display("FAIL level_status got=%h exp=%h", rd, 32'h9); end
      csr_wr(2'd0, 32'h2);
      trig_in = 1'b0;
      step();
      csr_rd(2'd1, rd);
      total++;
      if (rd !== 32'h0) begin bad++; $display("FAIL level_abort_status got=%h exp=0", rd); end
   endtask

   task automatic test_capture(input int n, input bit rnd);
      logic [31:0] rd;
      int dq[$];
      int cq[$];
      int k;
      int guard;
      csr_wr(2'd2, 32'(n));
      csr_wr(2'd0, 32'h1);
      step();
      wq.delete();
      // trigger cycle carries a valid sample that must be skipped
      trig_in   = 1'b1;
      smp_valid = 1'b1;
      smp_data  = 8'hEE;
      step();
      trig_in   = 1'b0;
      k         = 0;
      guard     = 0;
      while (k < n + 2 && guard < 500) begin
         guard++;
         if (!rnd || $urandom_range(0, 2) != 0) begin
            smp_valid = 1'b1;
            smp_data  = rnd ? 8'($urandom) : 8'(8'h11 + k);
            dq.push_back(int'(smp_data));
            cq.push_back(cyc);
            k++;
         end else begin
            smp_valid = 1'b0;
         end
         step();
      end
      smp_valid = 1'b0;
      repeat (3) step();
      total++;
      if (wq.size() != n) begin bad++; $display("FAIL cap_nwrites n=%0d got=%0d exp=%0d", n, wq.size(), n); end
      for (int i = 0; i < n && i < wq.size(); i++) begin
         total++;
         if (wq[i].a != i || wq[i].d != dq[i] || wq[i].c != cq[i] + 1) begin
            bad++;
            $display("FAIL cap_write[%0d] got addr=%0d data=%h cyc=%0d exp addr=%0d data=%h cyc=%0d",
                     i, wq[i].a, wq[i].d, wq[i].c, i, dq[i], cq[i] + 1);
         end
      end
      csr_rd(2'd1, rd);
      total++;
      if (rd !== 32'h2) begin bad++; $display("FAIL cap_status got=%h exp=%h", rd, 32'h2); end
      csr_rd(2'd3, rd);
      total++;
      if (rd !== 32'(n)) begin bad++; $display("FAIL cap_wptr got=%0d exp=%0d", rd, n); end
      csr_wr(2'd1, 32'h2);
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd;
      int dq[$];
      int cq[$];
      csr_wr(2'd2, 32'd0);
      csr_wr(2'd0, 32'h9);
      step();
      wq.delete();
      irq_rise  = -1;
      smp_valid = 1'b1;
      smp_data  = 8'hEE;
      csr_wr(2'd0, 32'hC);   // SW_TRIG with IRQ_EN kept; this cycle's sample is skipped
      for (int i = 0; i < 260; i++) begin
         smp_valid = 1'b1;
         smp_data  = 8'($urandom);
         dq.push_back(int'(smp_data));
         cq.push_back(cyc);
         step();
      end
      smp_valid = 1'b0;
      repeat (4) step();
      total++;
      if (wq.size() != 256) begin bad++; $display("FAIL b2b_nwrites got=%0d exp=256", wq.size()); end
      for (int i = 0; i < 256 && i < wq.size(); i++) begin
         total++;
         if (wq[i].a != i || wq[i].d != dq[i] || wq[i].c != cq[i] + 1) begin
            bad++;
            $display("FAIL b2b_write[%0d] got addr=%0d data=%h cyc=%0d exp addr=%0d data=%h cyc=%0d",
                     i, wq[i].a, wq[i].d, wq[i].c, i, dq[i], cq[i] + 1);
         end
      end
      if (wq.size() == 256) begin
         total++;
         if (irq_rise != wq[255].c + 1) begin
            bad++;
            $display("FAIL b2b_irq_rise got=%0d exp=%0d", irq_rise, wq[255].c + 1);
         end
      end
      total++;
      if (irq !== 1'b1) begin bad++; $display("FAIL b2b_irq_level got=%b exp=1", irq); end
      csr_wr(2'd1, 32'h2);
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL b2b_irq_clear got=%b exp=0", irq); end
      csr_rd(2'd3, rd);
      total++;
      if (rd !== 32'd256) begin bad++; $display("FAIL b2b_wptr got=%0d exp=256", rd); end
   endtask

   task automatic test_abort();
      logic [31:0] rd;
      int k;
      k = $urandom_range(1, 6);
      csr_wr(2'd2, 32'd8);
      csr_wr(2'd0, 32'h1);
      step();
      wq.delete();
      trig_in = 1'b1;
      step();
      trig_in = 1'b0;
      for (int i = 0; i < k; i++) begin
         smp_valid = 1'b1;
         smp_data  = 8'($urandom);
         step();
      end
      smp_valid = 1'b0;
      step();
      trig_in = 1'b1;   // second edge while capturing
      step();
      trig_in = 1'b0;
      csr_wr(2'd0, 32'h2);
      csr_rd(2'd1, rd);
      total++;
      if (rd !== 32'h4) begin bad++; $display("FAIL abort_status got=%h exp=%h", rd, 32'h4); end
      csr_rd(2'd3, rd);
      total++;
      if (rd !== 32'(k)) begin bad++; $display("FAIL abort_wptr got=%0d exp=%0d", rd, k); end
      total++;
      if (wq.size() != k) begin bad++; $display("FAIL abort_nwrites got=%0d exp=%0d", wq.size(), k); end
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL abort_irq got=%b exp=0", irq); end
      csr_wr(2'd1, 32'h4);
      csr_rd(2'd1, rd);
      total++;
      if (rd !== 32'h0) begin bad++; $display("FAIL lost_w1c got=%h exp=0", rd); end
      csr_wr(2'd0, 32'h3);   // ARM with ABORT in one write
      csr_rd(2'd1, rd);
      total++;
      if (rd !== 32'h0) begin bad++; $display("FAIL arm_abort_status got=%h exp=0", rd); end
   endtask

   task automatic test_count_clamp();
      logic [31:0] rd;
      logic [31:0] v;
      logic [31:0] e;
      for (int i = 0; i < 8; i++) begin
         case (i)
            0: v = 32'd0;
            1: v = 32'd256;
            2: v = 32'd257;
            3: v = 32'd1;
            4: v = $urandom;
            default: v = $urandom_range(0, 300);
         endcase
         e = (v == 0 || v > 256) ? 32'd256 : v;
         csr_wr(2'd2, v);
         csr_rd(2'd2, rd);
         total++;
         if (rd !== e) begin bad++; $display("FAIL count_clamp wrote=%0d got=%0d exp=%0d", v, rd, e); end
      end
   endtask

   task automatic test_reset_mid_capture();
      logic [31:0] rd;
      csr_wr(2'd2, 32'd50);
      csr_wr(2'd0, 32'h9);
      csr_wr(2'd0, 32'hC);
      for (int i = 0; i < 10; i++) begin
         smp_valid = 1'b1;
         smp_data  = 8'($urandom);
         step();
      end
      reset = 1'b1;
      step();
      wq.delete();
      total++;
      if ({avs_readdata, ram_address, ram_writedata, ram_write, ram_chipselect, irq} !== '0) begin
         bad++;
         $display("FAIL midrst_outputs rd=%h addr=%h data=%h wr=%b cs=%b irq=%b exp all 0",
                  avs_readdata, ram_address, ram_writedata, ram_write, ram_chipselect, irq);
      end
      repeat (2) step();
      reset = 1'b0;
      repeat (3) step();
      smp_valid = 1'b0;
      step();
      total++;
      if (wq.size() != 0) begin bad++; $display("FAIL midrst_no_write got=%0d exp=0", wq.size()); end
      csr_rd(2'd1, rd);
      total++;
      if (rd !== 32'h0) begin bad++; $display("FAIL midrst_status got=%h exp=0", rd); end
      csr_rd(2'd2, rd);
      total++;
      if (rd !== 32'd256) begin bad++; $display("FAIL midrst_count got=%0d exp=256", rd); end
      csr_rd(2'd0, rd);
      total++;
      if (rd !== 32'h0) begin bad++; $display("FAIL midrst_ctrl got=%h exp=0", rd); end
   endtask

`ifdef RANGEFINDER_CAPTURE_DECIM_EN
   task automatic test_decim(input int d, input int n, input bit rnd);
      logic [31:0] rd;
      int dq[$];
      int idx;
      int guard;
      csr_wr(2'd3, 32'(d) << 24);
      csr_wr(2'd2, 32'(n));
      csr_wr(2'd0, 32'h1);
      step();
      wq.delete();
      trig_in = 1'b1;
      step();
      trig_in = 1'b0;
      idx     = 0;
      guard   = 0;
      while (idx < n * (d + 1) + 3 && guard < 500) begin
         guard++;
         if (!rnd || $urandom_range(0, 2) != 0) begin
            smp_valid = 1'b1;
            smp_data  = rnd ? 8'($urandom) : 8'(idx + 1);
            if (idx % (d + 1) == 0 && dq.size() < n) dq.push_back(int'(smp_data));
            idx++;
         end else begin
            smp_valid = 1'b0;
         end
         step();
      end
      smp_valid = 1'b0;
      repeat (3) step();
      total++;
      if (wq.size() != n) begin bad++; $display("FAIL decim_nwrites got=%0d exp=%0d", wq.size(), n); end
      for (int i = 0; i < n && i < wq.size(); i++) begin
         total++;
         if (wq[i].a != i || wq[i].d != dq[i]) begin
            bad++;
            $display("FAIL decim_write[%0d] got addr=%0d data=%h exp addr=%0d data=%h",
                     i, wq[i].a, wq[i].d, i, dq[i]);
         end
      end
      csr_rd(2'd3, rd);
      total++;
      if (rd !== ((32'(d) << 24) | 32'(n))) begin
         bad++;
         $display("FAIL decim_wptr got=%h exp=%h", rd, (32'(d) << 24) | 32'(n));
      end
      csr_wr(2'd1, 32'h2);
      csr_wr(2'd3, 32'h0);
   endtask
`else
   task automatic test_wptr_readonly();
      logic [31:0] rd;
      csr_wr(2'd3, 32'hFF00_0055);
      csr_rd(2'd3, rd);
      total++;
      if (rd !== 32'h0) begin bad++; $display("FAIL wptr_readonly got=%h exp=0", rd); end
   endtask
`endif

   initial begin
      reset          = 1'b1;
      avs_address    = '0;
      avs_chipselect = 1'b0;
      avs_write      = 1'b0;
      avs_read       = 1'b0;
      avs_writedata  = '0;
      smp_valid      = 1'b0;
      smp_data       = '0;
      trig_in        = 1'b0;

      test_reset();
      test_level_trigger();
      test_capture(4, 1'b0);
      for (int i = 0; i < 3; i++) test_capture(int'($urandom_range(1, 12)), 1'b1);
      test_back_to_back();
      test_abort();
      test_count_clamp();
      test_reset_mid_capture();
`ifdef RANGEFINDER_CAPTURE_DECIM_EN
      test_decim(2, 3, 1'b0);
      test_decim(int'($urandom_range(0, 3)), int'($urandom_range(2, 5)), 1'b1);
`else
      test_wptr_readonly();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
